// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiplier and restoring divider
// sharing one 2*XLEN working register, fixed XLEN-cycle latency, single-cycle writeback.
module mul_div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic            wb_en,
  output logic [4:0]      wb_select,
  output logic [XLEN-1:0] wb_data
);

  localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef struct packed {
    logic [2:0]      op;
    logic [4:0]      rd;
    logic [XLEN-1:0] a;       // raw dividend, returned by REM on divide-by-zero
    logic            b_zero;
    logic            neg_res;
  } req_t;

  state_t            state;
  req_t              req;
  logic [CW-1:0]     counter;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   b_mag;

  // Operand decode at accept time
  logic            is_div, a_signed, b_signed, neg_a_in, neg_b_in, neg_res_in;
  logic [XLEN-1:0] mag_a, mag_b;

  always_comb begin
    is_div     = funct3[2];
    a_signed   = is_div ? ~funct3[0] : (funct3 == 3'b001 || funct3 == 3'b010);
    b_signed   = is_div ? ~funct3[0] : (funct3 == 3'b001);
    neg_a_in   = a_signed & operand_a[XLEN-1];
    neg_b_in   = b_signed & operand_b[XLEN-1];
    mag_a      = neg_a_in ? -operand_a : operand_a;
    mag_b      = neg_b_in ? -operand_b : operand_b;
    // Remainder sign follows the dividend; everything else is the product of signs
    neg_res_in = (is_div && funct3[1]) ? neg_a_in : (neg_a_in ^ neg_b_in);
  end

  // One iteration of the shared datapath
  logic [XLEN:0]     mul_sum, rem_sh, diff;
  logic [2*XLEN-1:0] acc_nxt;

  always_comb begin
    mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b_mag} : {(XLEN+1){1'b0}});
    rem_sh  = acc[2*XLEN-1:XLEN-1];
    diff    = rem_sh - {1'b0, b_mag};
    if (req.op[2]) begin
      if (diff[XLEN]) acc_nxt = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
      else            acc_nxt = {diff[XLEN-1:0],   acc[XLEN-2:0], 1'b1};
    end else begin
      acc_nxt = {mul_sum, acc[XLEN-1:1]};
    end
  end

  // Sign fix-up and result select on the final iteration's value
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo, rem, result;

  always_comb begin
    prod_s = req.neg_res ? -acc_nxt : acc_nxt;
    quo    = req.neg_res ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
    rem    = req.neg_res ? -acc_nxt[2*XLEN-1:XLEN] : acc_nxt[2*XLEN-1:XLEN];
    unique case (req.op)
      3'b000:                 result = prod_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: result = prod_s[2*XLEN-1:XLEN];
      3'b100, 3'b101:         result = req.b_zero ? {XLEN{1'b1}} : quo;
      default:                result = req.b_zero ? req.a : rem;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      counter   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      wb_en     <= 1'b0;
      wb_select <= '0;
      wb_data   <= '0;
      acc       <= '0;
      b_mag     <= '0;
      req       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            req.op      <= funct3;
            req.rd      <= rd_in;
            req.a       <= operand_a;
            req.b_zero  <= (operand_b == '0);
            req.neg_res <= neg_res_in;
            // Low half holds multiplier or dividend; high half is the partial sum/remainder
            acc         <= {{XLEN{1'b0}}, mag_a};
            b_mag       <= mag_b;
            counter     <= '0;
            busy        <= 1'b1;
            state       <= RUN;
          end
        end
        RUN: begin
          acc     <= acc_nxt;
          counter <= counter + CW'(1);
          if (counter == CW'(XLEN-1)) begin
            state     <= DONE;
            done      <= 1'b1;
            wb_en     <= (req.rd != 5'd0);
            wb_select <= req.rd;
            wb_data   <= result;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          wb_en <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: hand-computed RV32M results, latency and control-path checks.
module tb_mul_div_unit;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] operand_a = '0, operand_b = '0;
  logic [4:0]  rd_in = '0;
  logic        busy, done, wb_en;
  logic [4:0]  wb_select;
  logic [31:0] wb_data;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  mul_div_unit #(.XLEN(32)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .funct3(funct3),
    .operand_a(operand_a), .operand_b(operand_b), .rd_in(rd_in),
    .busy(busy), .done(done), .wb_en(wb_en), .wb_select(wb_select), .wb_data(wb_data)
  );

  // Issues one op, scrambles inputs after accept, reports latency and writeback observations
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output int lat, output logic en,
                        output logic [4:0] sel, output logic [31:0] data,
                        output logic busy_after, output logic pulse_after);
    @(negedge clock);
    funct3 = f; operand_a = a; operand_b = b; rd_in = rd; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; operand_a = 32'hDEAD_BEEF; operand_b = 32'h1234_5678; rd_in = 5'd31; funct3 = 3'b111;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clock); #1;
      if (done) begin lat = i; break; end
    end
    en = wb_en; sel = wb_select; data = wb_data;
    @(posedge clock); #1;
    busy_after = busy; pulse_after = done | wb_en;
  endtask

  task automatic test_reset();
    #23;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (wb_en !== 1'b0) begin n_err++; $display("FAIL reset_wb_en: got %b want 0", wb_en); end
    n_cmp++; if (wb_select !== 5'd0) begin n_err++; $display("FAIL reset_wb_select: got %0d want 0", wb_select); end
    n_cmp++; if (wb_data !== 32'h0) begin n_err++; $display("FAIL reset_wb_data: got %h want 0", wb_data); end
    @(negedge clock); reset_n = 1'b1;
  endtask

  task automatic test_mul();
    int lat; logic en, ba, pa; logic [4:0] sel; logic [31:0] d;
    run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, lat, en, sel, d, ba, pa);
    n_cmp++; if (lat !== 32) begin n_err++; $display("FAIL mul_latency: got %0d want 32", lat); end
    n_cmp++; if (en !== 1'b1) begin n_err++; $display("FAIL mul_wb_en: got %b want 1", en); end
    n_cmp++; if (sel !== 5'd5) begin n_err++; $display("FAIL mul_wb_select: got %0d want 5", sel); end
    n_cmp++; if (d !== 32'hFFFF_FFEB) begin n_err++; $display("FAIL mul_data: got %h want ffffffeb", d); end
    n_cmp++; if (ba !== 1'b0) begin n_err++; $display("FAIL mul_busy_after: got %b want 0", ba); end
    n_cmp++; if (pa !== 1'b0) begin n_err++; $display("FAIL mul_pulse_width: done|wb_en got %b want 0", pa); end
  endtask

  task automatic test_mul_high();
    int lat; logic en, ba, pa; logic [4:0] sel; logic [31:0] d;
    run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd1, lat, en, sel, d, ba, pa);
    n_cmp++; if (d !== 32'h4000_0000) begin n_err++; $display("FAIL mulh: got %h want 40000000", d); end
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, lat, en, sel, d, ba, pa);
    n_cmp++; if (d !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL mulhu: got %h want fffffffe", d); end
    run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, lat, en, sel, d, ba, pa);
    n_cmp++; if (d !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL mulhsu: got %h want ffffffff", d); end
    n_cmp++; if (sel !== 5'd3) begin n_err++; $display("FAIL mulhsu_wb_select: got %0d want 3", sel); end
  endtask

  task automatic test_div();
    int lat; logic en, ba, pa; logic [4:0] sel; logic [31:0] d;
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd10, lat, en, sel, d, ba, pa);
    n_cmp++; if (d !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL div_neg: got %h want fffffffd", d); end
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd11, lat, en, sel, d, ba, pa);
    n_cmp++; if (d !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL rem_neg: got %h want ffffffff", d); end
    run_op(3'b101, 32'd100, 32'd7, 5'd12, lat, en, sel, d, ba, pa);
    n_cmp++; if (d !== 32'd14) begin n_err++; $display("FAIL divu: got %h want 0000000e", d); end
    run_op(3'b111, 32'd100, 32'd7, 5'd13, lat, en, sel, d, ba, pa);
    n_cmp++; if (d !== 32'd2) begin n_err++; $display("FAIL remu: got %h want 00000002", d); end
    n_cmp++; if (lat !== 32) begin n_err++; $display("FAIL remu_latency: got %0d want 32", lat); end
  endtask

  task automatic test_special();
    int lat; logic en, ba, pa; logic [4:0] sel; logic [31:0] d;
    run_op(3'b101, 32'd5, 32'd0, 5'd14, lat, en, sel, d, ba, pa);
    n_cmp++; if (d !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL divu_by_zero: got %h want ffffffff", d); end
    n_cmp++; if (lat !== 32) begin n_err++; $display("FAIL divu_by_zero_latency: got %0d want 32", lat); end
    run_op(3'b110, 32'd5, 32'd0, 5'd15, lat, en, sel, d, ba, pa);
    n_cmp++; if (d !== 32'd5) begin n_err++; $display("FAIL rem_by_zero: got %h want 00000005", d); end
    n_cmp++; if (lat !== 32) begin n_err++; $display("FAIL rem_by_zero_latency: got %0d want 32", lat); end
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, lat, en, sel, d, ba, pa);
    n_cmp++; if (d !== 32'h8000_0000) begin n_err++; $display("FAIL div_overflow: got %h want 80000000", d); end
    n_cmp++; if (lat !== 32) begin n_err++; $display("FAIL div_overflow_latency: got %0d want 32", lat); end
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, lat, en, sel, d, ba, pa);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL rem_overflow: got %h want 00000000", d); end
  endtask

  task automatic test_rd_zero();
    int lat; logic en, ba, pa; logic [4:0] sel; logic [31:0] d;
    run_op(3'b000, 32'd3, 32'd4, 5'd0, lat, en, sel, d, ba, pa);
    n_cmp++; if (lat !== 32) begin n_err++; $display("FAIL rd0_done_latency: got %0d want 32", lat); end
    n_cmp++; if (en !== 1'b0) begin n_err++; $display("FAIL rd0_wb_en: got %b want 0", en); end
    n_cmp++; if (d !== 32'd12) begin n_err++; $display("FAIL rd0_data: got %h want 0000000c", d); end
  endtask

  task automatic test_restart_ignored();
    int lat;
    @(negedge clock);
    funct3 = 3'b101; operand_a = 32'd100; operand_b = 32'd7; rd_in = 5'd9; start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      if (i == 10) begin
        @(negedge clock);
        funct3 = 3'b000; operand_a = 32'd1; operand_b = 32'd1; rd_in = 5'd4; start = 1'b1;
      end
      @(posedge clock); #1;
      if (i == 10) start = 1'b0;
      if (done) begin lat = i; break; end
    end
    n_cmp++; if (lat !== 32) begin n_err++; $display("FAIL restart_latency: got %0d want 32", lat); end
    n_cmp++; if (wb_data !== 32'd14) begin n_err++; $display("FAIL restart_data: got %h want 0000000e", wb_data); end
    n_cmp++; if (wb_select !== 5'd9) begin n_err++; $display("FAIL restart_wb_select: got %0d want 9", wb_select); end
    @(posedge clock); #1;
  endtask

  task automatic test_back_to_back();
    int d1, lat2;
    @(negedge clock);
    funct3 = 3'b000; operand_a = 32'd2; operand_b = 32'd5; rd_in = 5'd6; start = 1'b1;
    @(posedge clock); #1;
    d1 = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clock); #1;
      if (i == 10) begin operand_a = 32'd3; rd_in = 5'd7; end
      if (done) begin d1 = i; break; end
    end
    n_cmp++; if (d1 !== 32) begin n_err++; $display("FAIL b2b_first_latency: got %0d want 32", d1); end
    n_cmp++; if (wb_data !== 32'd10) begin n_err++; $display("FAIL b2b_first_data: got %h want 0000000a", wb_data); end
    @(posedge clock); #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_accept_in_done: busy got %b want 0", busy); end
    @(posedge clock); #1;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_accept_first_idle: busy got %b want 1", busy); end
    start = 1'b0;
    lat2 = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clock); #1;
      if (done) begin lat2 = i; break; end
    end
    n_cmp++; if (lat2 !== 32) begin n_err++; $display("FAIL b2b_second_latency: got %0d want 32", lat2); end
    n_cmp++; if (wb_data !== 32'd15) begin n_err++; $display("FAIL b2b_second_data: got %h want 0000000f", wb_data); end
    n_cmp++; if (wb_select !== 5'd7) begin n_err++; $display("FAIL b2b_second_wb_select: got %0d want 7", wb_select); end
    @(posedge clock); #1;
  endtask

  task automatic test_reset_mid_run();
    int lat; logic en, ba, pa; logic [4:0] sel; logic [31:0] d;
    @(negedge clock);
    funct3 = 3'b101; operand_a = 32'd100; operand_b = 32'd7; rd_in = 5'd3; start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
    repeat (10) @(posedge clock);
    #3; reset_n = 1'b0; #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midreset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL midreset_done: got %b want 0", done); end
    n_cmp++; if (wb_en !== 1'b0) begin n_err++; $display("FAIL midreset_wb_en: got %b want 0", wb_en); end
    n_cmp++; if (wb_data !== 32'h0) begin n_err++; $display("FAIL midreset_wb_data: got %h want 0", wb_data); end
    @(negedge clock); reset_n = 1'b1;
    run_op(3'b011, 32'd2, 32'd3, 5'd8, lat, en, sel, d, ba, pa);
    n_cmp++; if (lat !== 32) begin n_err++; $display("FAIL postreset_latency: got %0d want 32", lat); end
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL postreset_mulhu: got %h want 0", d); end
    n_cmp++; if (en !== 1'b1 || sel !== 5'd8) begin n_err++; $display("FAIL postreset_wb: en %b sel %0d want 1/8", en, sel); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mul_high();
    test_div();
    test_special();
    test_rd_zero();
    test_restart_ignored();
    test_back_to_back();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative RV32M multiply/divide unit in the execute stage, directly downstream of the register file read ports.
- Consumes reg_1/reg_2 operands and produces a single-cycle writeback (enable, destination, data) that drives the register file write port.
- Fixed-latency shift-add multiplier and restoring divider share one 2*XLEN-bit working register.
- One clock; reset is asynchronous and active-low.

Parameters:
XLEN, 32, operand/result width; iteration count equals XLEN

Ports:
clock  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
start  input  1  request; sampled on rising edge only when busy=0
funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
operand_a  input  XLEN  rs1 value (from reg_1)
operand_b  input  XLEN  rs2 value (from reg_2)
rd_in  input  5  destination register index
busy  output  1  high from accepting edge through DONE cycle
done  output  1  one-cycle completion pulse
wb_en  output  1  register file write enable; one-cycle pulse
wb_select  output  5  destination index, valid while done=1
wb_data  output  XLEN  result, valid while done=1

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE; counter=0; busy, done, wb_en = 0; wb_select = 0; wb_data = 0. An in-flight operation is discarded. start is ignored while reset is asserted.
- States: IDLE, RUN, DONE.
- IDLE: on an edge with start=1:
  - latch funct3, rd_in, operand_a, operand_b;
  - convert signed operands to magnitudes and record the result sign;
  - counter=0; go to RUN; busy=1.
- Signedness per op:
  - MULH, DIV, REM: both operands signed.
  - MULHSU: a signed, b unsigned.
  - All other ops: unsigned.
- RUN: one iteration per edge.
  - Multiply: shift-add on a 2*XLEN product register.
  - Divide: restoring shift-subtract producing quotient and remainder.
  - Counter increments; on the edge where counter reaches XLEN-1, the final iteration completes and the state goes to DONE.
  - Sign fix-up and result select are registered on that same edge.
- Latency: the accepting edge is edge 0. done/wb_en go high after edge XLEN and stay high for exactly one cycle. Latency is fixed for every op and operand value, including the special cases.
- DONE:
  - done=1, busy=1;
  - wb_en=1 unless the latched rd is 0, in which case wb_en=0 and done still pulses;
  - wb_select=latched rd; wb_data=result;
  - next edge: IDLE, busy=0, done=0, wb_en=0.
  - wb_select and wb_data hold their last values until the next completion.
- Back-to-back: start asserted during the DONE cycle is ignored. The earliest new accept is the first IDLE edge, so throughput is one op per XLEN+2 cycles.
- start and operand changes while busy=1 have no effect on the in-flight result.
- Result selection:
  - MUL: low XLEN bits of the product.
  - MULH, MULHSU, MULHU: high XLEN bits of the signed/unsigned product.
  - DIV/DIVU: quotient truncated toward zero.
  - REM/REMU: remainder; sign follows the dividend.
- Divide by zero (b=0): DIV/DIVU return all ones; REM/REMU return operand_a.
- Signed overflow (DIV with a=0x8000_0000, b=0xFFFF_FFFF): quotient 0x8000_0000, REM 0.
- Special cases are handled in the result select; no exceptions are raised and latency is unchanged.
- All arithmetic is modulo 2^XLEN on the outputs. No X propagation from unused operand bits.

Test Plan:
1. MUL a=7, b=0xFFFF_FFFD, rd=5 -> done, wb_en high exactly 32 cycles after the accepting edge for one cycle; wb_select=5; wb_data=0xFFFF_FFEB; busy low the cycle after.
2. High-half products:
   - MULH 0x8000_0000 x 0x8000_0000 -> 0x4000_0000
   - MULHU 0xFFFF_FFFF x 0xFFFF_FFFF -> 0xFFFF_FFFE
   - MULHSU 0xFFFF_FFFF x 0xFFFF_FFFF -> 0xFFFF_FFFF
3. Division:
   - DIV -7/2 -> 0xFFFF_FFFD; REM -7/2 -> 0xFFFF_FFFF
   - DIVU 100/7 -> 14; REMU 100/7 -> 2
4. Special cases, each still 32-cycle latency:
   - DIVU 5/0 -> 0xFFFF_FFFF; REM 5/0 -> 5
   - DIV 0x8000_0000/0xFFFF_FFFF -> 0x8000_0000; REM of the same -> 0
5. Control-path checks:
   - rd=0 MUL 3x4 -> done pulses, wb_en stays 0.
   - start re-pulsed with new operands at cycle 10 of a run -> ignored; the original result is delivered.
   - start held high through DONE -> next accept occurs only at the first IDLE edge.
6. Reset mid-run: reset_n low at cycle 10 of a DIVU run -> busy, done, wb_en, wb_data read 0 immediately, before any clock edge; after release, MULHU 2x3 completes normally with wb_data=0.
